// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with majority vote, parity and stop checking
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;
    state_t state_next;

    // frame configuration, frozen at the start edge
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic                  cfg_par_en;
    logic                  cfg_par_typ;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [1:0]            samp;
    logic                  par_mis;

    logic [PRESCALE_W-1:0] half;
    logic                  at_samp0;
    logic                  at_samp1;
    logic                  at_vote;
    logic                  at_last;
    logic                  vote;
    logic                  exp_par;

    // mid-bit sample points and the 2-of-3 vote (third sample is the live line)
    always_comb begin
        half     = cfg_prescale >> 1;
        at_samp0 = (edge_cnt == (half - ONE));
        at_samp1 = (edge_cnt == half);
        at_vote  = (edge_cnt == (half + ONE));
        at_last  = (edge_cnt == (cfg_prescale - ONE));
        vote     = (samp[0] & samp[1]) | (samp[0] & RX_IN) | (samp[1] & RX_IN);
        exp_par  = (^shift_reg) ^ cfg_par_typ;
    end

    // state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode; STOP leaves at the vote point so a back-to-back start is seen
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_next = START;
                end
            end
            START: begin
                if (at_vote && vote) begin
                    state_next = IDLE;
                end else if (at_last) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (at_last && (bit_cnt == LAST_BIT)) begin
                    state_next = cfg_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_last) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (at_vote) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // counters, sampling, deserialiser and one-cycle result pulses
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cfg_prescale <= '0;
            cfg_par_en   <= 1'b0;
            cfg_par_typ  <= 1'b0;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            samp         <= '0;
            par_mis      <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state == IDLE) begin
                bit_cnt <= '0;
                par_mis <= 1'b0;
                if (!RX_IN) begin
                    // this cycle is edge 0 of the start bit
                    edge_cnt     <= ONE;
                    cfg_prescale <= prescale;
                    cfg_par_en   <= PAR_EN;
                    cfg_par_typ  <= PAR_TYP;
                end else begin
                    edge_cnt <= '0;
                end
            end else begin
                if ((state_next == IDLE) || at_last) begin
                    edge_cnt <= '0;
                end else begin
                    edge_cnt <= edge_cnt + ONE;
                end

                if (at_samp0) begin
                    samp[0] <= RX_IN;
                end
                if (at_samp1) begin
                    samp[1] <= RX_IN;
                end

                case (state)
                    DATA: begin
                        if (at_vote) begin
                            shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
                        end
                        if (at_last && (bit_cnt != LAST_BIT)) begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end
                    PARITY: begin
                        if (at_vote) begin
                            par_mis <= (vote != exp_par);
                        end
                    end
                    STOP: begin
                        if (at_vote) begin
                            par_err <= par_mis;
                            stp_err <= ~vote;
                            if (vote && !par_mis) begin
                                data_valid <= 1'b1;
                                P_DATA     <= shift_reg;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .prescale  (prescale),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
    } pulse_t;

    pulse_t obs[$];

    always @(negedge CLK) begin
        if (data_valid || par_err || stp_err) begin
            obs.push_back('{cyc, data_valid, par_err, stp_err, P_DATA});
        end
    end

    typedef struct {
        int         ps;
        bit         pen;
        bit         ptyp;
        logic [7:0] data;
        bit         pbit;
        bit         stopb;
        int         gap;
        bit         exp_dv;
        bit         exp_pe;
        bit         exp_se;
        logic [7:0] exp_pd;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_bits(input logic b, input int n);
        RX_IN = b;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic int other_ps(input int ps);
        return (ps == 8) ? 16 : (ps == 16) ? 32 : 8;
    endfunction

    // start bit, data LSB-first, optional parity, stop; config scrambled while data is on the line
    task automatic send_frame(input int ps, input bit pen, input bit ptyp, input logic [7:0] d,
                              input bit pbit, input bit stopb, output int start_cyc);
        prescale  = 6'(ps);
        PAR_EN    = pen;
        PAR_TYP   = ptyp;
        start_cyc = cyc;
        drive_bits(1'b0, 1);
        prescale = 6'(other_ps(ps));
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
        drive_bits(1'b0, ps - 1);
        for (int i = 0; i < 8; i++) begin
            drive_bits(d[i], ps);
        end
        prescale = 6'(ps);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        if (pen) begin
            drive_bits(pbit, ps);
        end
        drive_bits(stopb, ps);
    endtask

    function automatic int exp_cycle(input int start, input int ps, input bit pen);
        return start + (9 + int'(pen)) * ps + ps / 2 + 2;
    endfunction

    task automatic check_frame(input string name, input bit edv, input bit epe, input bit ese,
                               input logic [7:0] epd, input int ecyc);
        int n_exp;
        n_exp = (edv || epe || ese) ? 1 : 0;
        chk({name, " pulse_count"}, obs.size(), n_exp);
        if (n_exp == 1 && obs.size() == 1) begin
            chk({name, " pulse_cycle"}, obs[0].cyc, ecyc);
            chk({name, " data_valid"}, obs[0].dv, edv);
            chk({name, " par_err"}, obs[0].pe, epe);
            chk({name, " stp_err"}, obs[0].se, ese);
            chk({name, " p_data_at_pulse"}, obs[0].pd, epd);
        end
        chk({name, " p_data_hold"}, P_DATA, epd);
        obs.delete();
    endtask

    vec_t       tbl[7];
    int         s0;
    int         s1;
    logic [7:0] model_pd;

    initial begin
        tbl[0] = '{8,  0, 0, 8'hA5, 0, 1, 4,  1, 0, 0, 8'hA5};
        tbl[1] = '{16, 1, 0, 8'h3C, 1, 1, 4,  0, 1, 0, 8'hA5};
        tbl[2] = '{8,  1, 1, 8'h01, 0, 0, 40, 0, 0, 1, 8'hA5};
        tbl[3] = '{16, 1, 0, 8'h3C, 0, 1, 0,  1, 0, 0, 8'h3C};
        tbl[4] = '{32, 1, 1, 8'h7E, 0, 0, 60, 0, 1, 1, 8'h3C};
        tbl[5] = '{32, 0, 0, 8'h00, 0, 1, 2,  1, 0, 0, 8'h00};
        tbl[6] = '{8,  1, 1, 8'hFE, 0, 1, 3,  1, 0, 0, 8'hFE};

        RST      = 1'b0;
        RX_IN    = 1'b1;
        prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset p_data", P_DATA, 8'h00);
        chk("reset data_valid", data_valid, 1'b0);
        chk("reset par_err", par_err, 1'b0);
        chk("reset stp_err", stp_err, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        drive_bits(1'b1, 10);
        obs.delete();

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].ps, tbl[i].pen, tbl[i].ptyp, tbl[i].data, tbl[i].pbit, tbl[i].stopb, s0);
            drive_bits(1'b1, tbl[i].gap);
            check_frame($sformatf("vec%0d", i), tbl[i].exp_dv, tbl[i].exp_pe, tbl[i].exp_se,
                        tbl[i].exp_pd, exp_cycle(s0, tbl[i].ps, tbl[i].pen));
        end

        // start glitch: two low cycles are voted away, then a real frame
        prescale = 6'd8;
        PAR_EN   = 1'b0;
        drive_bits(1'b0, 2);
        drive_bits(1'b1, 20);
        check_frame("glitch", 0, 0, 0, 8'hFE, 0);
        send_frame(8, 0, 0, 8'h5A, 0, 1, s0);
        drive_bits(1'b1, 4);
        check_frame("after_glitch", 1, 0, 0, 8'h5A, exp_cycle(s0, 8, 0));

        // back-to-back frames at prescale 32 with no idle gap
        send_frame(32, 0, 0, 8'hFF, 0, 1, s0);
        send_frame(32, 0, 0, 8'h00, 0, 1, s1);
        drive_bits(1'b1, 4);
        chk("b2b pulse_count", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("b2b first_cycle", obs[0].cyc, exp_cycle(s0, 32, 0));
            chk("b2b spacing", obs[1].cyc - obs[0].cyc, 320);
            chk("b2b first_data", obs[0].pd, 8'hFF);
            chk("b2b second_data", obs[1].pd, 8'h00);
            chk("b2b both_valid", {obs[0].dv, obs[1].dv, obs[0].pe | obs[0].se | obs[1].pe | obs[1].se}, 3'b110);
        end
        obs.delete();

        // reset during the 4th data bit aborts the frame
        prescale = 6'd16;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        drive_bits(1'b0, 16);
        drive_bits(1'b1, 16);
        drive_bits(1'b1, 16);
        drive_bits(1'b0, 16);
        drive_bits(1'b1, 8);
        RST = 1'b0;
        @(negedge CLK);
        chk("midreset p_data", P_DATA, 8'h00);
        chk("midreset pulses", {data_valid, par_err, stp_err}, 3'b000);
        drive_bits(1'b0, 5);
        RST = 1'b1;
        drive_bits(1'b1, 200);
        check_frame("aborted", 0, 0, 0, 8'h00, 0);
        send_frame(16, 0, 0, 8'h81, 0, 1, s0);
        drive_bits(1'b1, 4);
        check_frame("post_reset", 1, 0, 0, 8'h81, exp_cycle(s0, 16, 0));

        // randomized frames against the frame-level outcome model
        model_pd = 8'h81;
        for (int n = 0; n < 40; n++) begin
            int         ps;
            bit         pen;
            bit         ptyp;
            logic [7:0] d;
            bit         pbit;
            bit         stopb;
            bit         epe;
            bit         ese;
            bit         edv;
            int         gap;
            ps    = 8 << $urandom_range(0, 2);
            pen   = 1'($urandom_range(0, 1));
            ptyp  = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            pbit  = (^d) ^ ptyp ^ ($urandom_range(0, 3) == 0);
            stopb = ($urandom_range(0, 4) != 0);
            epe   = pen && (pbit != ((^d) ^ ptyp));
            ese   = !stopb;
            edv   = !epe && !ese;
            if (edv) begin
                model_pd = d;
            end
            gap = stopb ? int'($urandom_range(0, 3)) : ps + int'($urandom_range(5, 10));
            send_frame(ps, pen, ptyp, d, pbit, stopb, s0);
            drive_bits(1'b1, gap);
            check_frame($sformatf("rand%0d", n), edv, epe, ese, model_pd, exp_cycle(s0, ps, pen));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the existing UART transmit path, which drives start, data, parity and stop bits onto TX_OUT.
- Oversamples serial line RX_IN with a runtime prescale and majority-votes three mid-bit samples.
- Deserialises LSB-first data, checks optional parity and the stop bit, and presents the parallel byte with a one-cycle valid pulse.
- Sits between the pad-side synchroniser and the system-side RX FIFO.

Parameters:
DATA_WIDTH, 8, data bits per frame.
PRESCALE_W, 6, width of the prescale input.

Ports:
CLK  input  1  oversampling clock, rising-edge.
RST  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, idle high, already synchronised to CLK.
prescale  input  PRESCALE_W  samples per bit; legal values 8, 16, 32.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_WIDTH  received data word.
data_valid  output  1  one-cycle pulse: P_DATA holds a good frame.
par_err  output  1  one-cycle pulse: parity mismatch.
stp_err  output  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE; all counters and the shift register clear.
  - P_DATA=0, data_valid=0, par_err=0, stp_err=0.
  - Reset mid-frame aborts the frame with no output pulse.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - edge_cnt runs 0..prescale-1 within each bit.
  - bit_cnt runs 0..DATA_WIDTH-1 in DATA.
- Configuration capture:
  - prescale, PAR_EN and PAR_TYP are captured in the cycle IDLE sees RX_IN=0.
  - Changes during a frame are ignored.
- IDLE:
  - When RX_IN=0, go to START.
  - That cycle counts as edge_cnt=0 of the start bit.
- Sampling, for H = prescale/2:
  - RX_IN is sampled at edge_cnt = H-1, H and H+1.
  - Bit value is the majority of the 3 samples, resolved at edge_cnt = H+1.
- START:
  - If the voted value is 1, it is a glitch: return to IDLE at the next cycle with no outputs.
  - Otherwise, at edge_cnt = prescale-1 go to DATA with edge_cnt = 0.
- DATA:
  - Voted bit is shifted in LSB-first; the first data bit lands in P_DATA[0].
  - After bit DATA_WIDTH-1 completes (edge_cnt = prescale-1), go to PARITY if PAR_EN=1, else STOP.
- PARITY:
  - Expected parity is XOR of the received bits for even, its inverse for odd.
  - The mismatch flag is held until the frame ends.
  - At edge_cnt = prescale-1 go to STOP.
- STOP:
  - The vote is resolved at edge_cnt = H+1.
  - In the next cycle the FSM returns to IDLE (mid-bit exit), so a back-to-back start edge is caught.
  - In that same cycle exactly one of the following outcomes is pulsed for 1 cycle:
    - data_valid=1 with P_DATA updated, if parity is ok (or disabled) and stop=1;
    - par_err=1 if the parity mismatched;
    - stp_err=1 if stop=0.
  - par_err and stp_err may pulse together. data_valid is never asserted with either.
- P_DATA:
  - Updates only on data_valid.
  - Otherwise holds the last good word.
- Latency: data_valid rises H+2 cycles after the first CLK edge of the stop bit.
- Idle-low line: a stop error is reported, then IDLE immediately re-detects RX_IN=0 as a new start.
- Illegal prescale values: behaviour undefined; the bench does not drive them.

Test Plan:
1. prescale=8, PAR_EN=0, frame 0,0xA5 LSB-first,1 (8 cycles/bit) -> single data_valid pulse, P_DATA=0xA5, no error pulses.
2. prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C, parity bit 1 (wrong; even parity of 0x3C is 0) -> par_err=1 for 1 cycle, data_valid=0, P_DATA keeps its previous value.
3. prescale=8, PAR_EN=1, PAR_TYP=1, data 0x01, parity 0, stop bit 0 -> stp_err=1 for 1 cycle, par_err=0, data_valid=0.
4. prescale=8, RX_IN low for 2 cycles then high -> start vote=1, FSM back to IDLE, no output pulses; a following valid 0x5A frame yields data_valid with P_DATA=0x5A.
5. prescale=32, two back-to-back frames 0xFF then 0x00, no idle gap -> two data_valid pulses 320 cycles apart with P_DATA=0xFF then 0x00.
6. prescale=16, RST=0 asserted during the 4th data bit, then released, then a clean 0x81 frame -> outputs 0 during reset, no pulse for the aborted frame, then data_valid with P_DATA=0x81.
